synapse_integrator: RTL and testbench
=====================================

// Module: synapse_integrator
// PURPOSE
//  Upstream feeder of the neuron core: converts presynaptic spike pulses into the
//  signed Q16.16 synaptic current I that the core's integrator consumes.
//  Detects rising edges on N_SYN spike lines and weights each spike from a
//  writable weight table. Applies first-order exponential decay to a synaptic
//  state and adds a constant bias current; I is a registered output updated once per frame.
// PARAMETERS
//  WIDTH      32   data width, signed Q(WIDTH-16).16 fixed point
//  N_SYN      16   number of presynaptic inputs (>=2)
//  TAU_SHIFT  3    decay per frame: s -= s >>> TAU_SHIFT (1..WIDTH-2)
// PORTS
//  clk       in   1                 clock, rising edge
//  reset     in   1                 reset, asynchronous, active-high
//  syn_in    in   N_SYN             presynaptic spike levels (pulses held several clocks)
//  w_we      in   1                 weight table write enable
//  w_addr    in   $clog2(N_SYN)     weight table write index
//  w_data    in   WIDTH (signed)    weight value, Q16.16
//  bias      in   WIDTH (signed)    constant current added to I, sampled in UPDATE
//  I         out  WIDTH (signed)    synaptic current to neuron core, registered
//  i_update  out  1                 1-cycle pulse: I changed this cycle
// BEHAVIOUR
//  Reset: I=0, i_update=0, synaptic state s=0, acc=0, all weights=0, pending=0,
//   syn_prev=0, FSM=SCAN with idx=0. Reset mid-frame discards acc and pending.
//  Edge detect: rise = syn_in & ~syn_prev; syn_prev <= syn_in every cycle.
//   Line held high counts as exactly one spike. Line high at reset release counts once.
//  pending[k] set on rise[k]; cleared when scanned. Rise in the same cycle as the clear
//   keeps the bit set (spike counted next frame). Multiple rises before scan = one spike.
//  FSM, frame = N_SYN+1 cycles, free-running:
//   SCAN (idx 0..N_SYN-1): if pending[idx]: acc += weight[idx]. idx==N_SYN-1 -> UPDATE.
//   UPDATE: s_next = sat(s - (s >>> TAU_SHIFT) + acc); s <= s_next;
//           I <= sat(s_next + bias); i_update <= 1 (next cycle only); acc <= 0; idx <= 0; -> SCAN.
//  Arithmetic: acc and intermediate sums WIDTH+$clog2(N_SYN)+1 bits signed; sat() clamps
//   to [0x8000_0000, 0x7FFF_FFFF] for WIDTH=32 (generally signed WIDTH min/max).
//   >>> is arithmetic; s=-1 LSB decays to 0. Decay truncates toward -inf.
//  Latency: spike rise to I change <= 2*(N_SYN+1)+1 cycles; min 2 cycles (rise at scanned idx-1).
//  Weight write: synchronous, takes effect next cycle; a write to the idx scanned in the same
//   cycle uses the old weight. Writes allowed in any state.
//  I holds its value between UPDATEs; the core samples it every clock.
// TESTING (N_SYN=4, TAU_SHIFT=3, frame=5 cycles, bias=0 unless stated)
//  T1 weight[1]=0x0002_0000, pulse syn_in[1] 8 cycles -> next UPDATE I=0x0002_0000,
//     then 0x0001_C000, 0x0001_8800, ... one i_update pulse per frame.
//  T2 weight[0]=0x0001_0000, syn_in[0] held high 20 cycles -> counted once: I peaks 0x0001_0000.
//  T3 all weights 0x7000_0000, all lines pulse -> I=0x7FFF_FFFF; weights 0x9000_0000 -> I=0x8000_0000.
//  T4 bias=0xFFF6_0000, no spikes -> every i_update I=0xFFF6_0000 (-10.0); s stays 0.
//  T5 rise on syn_in[2] in the cycle idx=2 clears pending[2] -> counted in following frame only.
//  T6 assert reset mid-SCAN with pending spikes -> I=0, i_update=0 immediately; after release
//     first i_update 5 cycles later with I=0 (if syn_in low).

Source files
------------

// File: rtl/synapse_integrator.sv
// Synapse integrator: turns presynaptic spike pulses into a signed fixed-point
// synaptic current I for the neuron core. Rising edges on the spike lines are
// latched as pending spikes. A free-running frame of N_SYN+1 cycles scans the
// lines and sums their weights. It then applies exponential decay to the
// synaptic state, adds the bias and registers the result on I.
module synapse_integrator #(
   parameter int WIDTH     = 32,
   parameter int N_SYN     = 16,
   parameter int TAU_SHIFT = 3
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [N_SYN-1:0]              syn_in,
   input  logic                          w_we,
   input  logic [$clog2(N_SYN)-1:0]      w_addr,
   input  logic signed [WIDTH-1:0]       w_data,
   input  logic signed [WIDTH-1:0]       bias,
   output logic signed [WIDTH-1:0]       I,
   output logic                          i_update
);

   localparam int IDX_W = $clog2(N_SYN);
   // Wide enough for N_SYN full-scale weights plus the decayed state without wrap.
   localparam int SUM_W = WIDTH + IDX_W + 1;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SYN - 1);

   localparam logic signed [WIDTH-1:0] MAX_W = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic signed [WIDTH-1:0] MIN_W = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic signed [SUM_W-1:0] MAX_EXT = {{(SUM_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
   localparam logic signed [SUM_W-1:0] MIN_EXT = {{(SUM_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

   typedef enum logic {
      SCAN   = 1'b0,
      UPDATE = 1'b1
   } state_t;

   state_t                    state_reg, state_next;
   logic [IDX_W-1:0]          idx_reg, idx_next;
   logic signed [SUM_W-1:0]   acc_reg, acc_next;
   logic signed [WIDTH-1:0]   s_reg;
   logic [N_SYN-1:0]          syn_prev_reg;
   logic [N_SYN-1:0]          pending_reg, pending_next;
   logic [N_SYN-1:0]          rise;
   logic [N_SYN-1:0]          scan_clear;
   logic signed [WIDTH-1:0]   weight_reg [N_SYN];

   logic                      update_fire;
   logic signed [WIDTH-1:0]   weight_sel;
   logic signed [SUM_W-1:0]   weight_ext;
   logic signed [SUM_W-1:0]   s_ext;
   logic signed [SUM_W-1:0]   decay_ext;
   logic signed [SUM_W-1:0]   s_sum;
   logic signed [WIDTH-1:0]   s_sat;
   logic signed [SUM_W-1:0]   s_sat_ext;
   logic signed [SUM_W-1:0]   bias_ext;
   logic signed [SUM_W-1:0]   i_sum;
   logic signed [WIDTH-1:0]   i_sat;

   // Clamp a wide signed sum into the signed WIDTH range.
   function automatic logic signed [WIDTH-1:0] sat(input logic signed [SUM_W-1:0] v);
      logic signed [WIDTH-1:0] r;
      if (v > MAX_EXT) begin
         r = MAX_W;
      end else if (v < MIN_EXT) begin
         r = MIN_W;
      end else begin
         r = v[WIDTH-1:0];
      end
      return r;
   endfunction

   // Edge detection: a line counts as a spike only on its low-to-high transition.
   assign rise = syn_in & ~syn_prev_reg;

   // Remember the previous spike levels every cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         syn_prev_reg <= '0;
      end else begin
         syn_prev_reg <= syn_in;
      end
   end

   // Per-line pending bit: cleared when its index is scanned, but a rise in the
   // same cycle wins so that spike is counted in the next frame.
   generate
      for (genvar gi = 0; gi < N_SYN; gi++) begin : g_line
         assign scan_clear[gi]   = (state_reg == SCAN) && (idx_reg == IDX_W'(gi));
         assign pending_next[gi] = (pending_reg[gi] & ~scan_clear[gi]) | rise[gi];

         // Pending spike latch for this line.
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               pending_reg[gi] <= 1'b0;
            end else begin
               pending_reg[gi] <= pending_next[gi];
            end
         end

         // Weight entry; a write lands next cycle, so a same-cycle scan sees the old value.
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               weight_reg[gi] <= '0;
            end else if (w_we && (w_addr == IDX_W'(gi))) begin
               weight_reg[gi] <= w_data;
            end
         end
      end
   endgenerate

   // Datapath: weight selection, decay, saturation and bias addition.
   always_comb begin
      weight_sel = weight_reg[idx_reg];
      weight_ext = {{(SUM_W-WIDTH){weight_sel[WIDTH-1]}}, weight_sel};
      s_ext      = {{(SUM_W-WIDTH){s_reg[WIDTH-1]}}, s_reg};
      // Arithmetic shift floors toward -inf, so a state of -1 LSB decays to 0.
      decay_ext  = s_ext >>> TAU_SHIFT;
      s_sum      = s_ext - decay_ext + acc_reg;
      s_sat      = sat(s_sum);
      s_sat_ext  = {{(SUM_W-WIDTH){s_sat[WIDTH-1]}}, s_sat};
      bias_ext   = {{(SUM_W-WIDTH){bias[WIDTH-1]}}, bias};
      i_sum      = s_sat_ext + bias_ext;
      i_sat      = sat(i_sum);
   end

   // Frame FSM state register: scan index, weight accumulator and phase.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= SCAN;
         idx_reg   <= '0;
         acc_reg   <= '0;
      end else begin
         state_reg <= state_next;
         idx_reg   <= idx_next;
         acc_reg   <= acc_next;
      end
   end

   // Frame FSM next-state logic: scan every line once, then one update cycle.
   always_comb begin
      state_next  = state_reg;
      idx_next    = idx_reg;
      acc_next    = acc_reg;
      update_fire = 1'b0;
      case (state_reg)
         SCAN: begin
            if (pending_reg[idx_reg]) begin
               acc_next = acc_reg + weight_ext;
            end
            if (idx_reg == LAST_IDX) begin
               state_next = UPDATE;
            end else begin
               idx_next = idx_reg + IDX_W'(1);
            end
         end
         UPDATE: begin
            update_fire = 1'b1;
            acc_next    = '0;
            idx_next    = '0;
            state_next  = SCAN;
         end
         default: begin
            state_next = SCAN;
            idx_next   = '0;
            acc_next   = '0;
         end
      endcase
   end

   // Synaptic state and output current, refreshed once per frame.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s_reg    <= '0;
         I        <= '0;
         i_update <= 1'b0;
      end else begin
         i_update <= update_fire;
         if (update_fire) begin
            s_reg <= s_sat;
            I     <= i_sat;
         end
      end
   end

endmodule

// File: tb/tb_synapse_integrator.sv
// Testbench for synapse_integrator: directed scenarios plus randomized traffic,
// checked by a frame-level reference model feeding a scoreboard queue.
module tb_synapse_integrator;

   localparam int W  = 32;
   localparam int N  = 4;
   localparam int TS = 3;

   localparam longint MAXV = 64'sd2147483647;
   localparam longint MINV = -64'sd2147483648;

   logic                 clk = 1'b0;
   logic                 reset = 1'b0;
   logic [N-1:0]         syn_in = '0;
   logic                 w_we = 1'b0;
   logic [1:0]           w_addr = '0;
   logic signed [W-1:0]  w_data = '0;
   logic signed [W-1:0]  bias = '0;
   logic signed [W-1:0]  I;
   logic                 i_update;

   int errors = 0;
   int checks = 0;

   longint sbq[$];
   longint obs[$];

   // Reference model state (frame-level view of the behaviour)
   longint        m_s;
   longint        m_acc;
   longint        m_w [N];
   logic [N-1:0]  m_pend;
   logic [N-1:0]  m_prev;
   int            m_phase;

   synapse_integrator #(.WIDTH(W), .N_SYN(N), .TAU_SHIFT(TS)) dut (
      .clk      (clk),
      .reset    (reset),
      .syn_in   (syn_in),
      .w_we     (w_we),
      .w_addr   (w_addr),
      .w_data   (w_data),
      .bias     (bias),
      .I        (I),
      .i_update (i_update)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act[31:0], exp[31:0]);
      end
   endtask

   function automatic longint sat32(input longint v);
      if (v > MAXV) return MAXV;
      if (v < MINV) return MINV;
      return v;
   endfunction

   // Floor division by 2^TS (decay truncates toward -inf)
   function automatic longint floor_div(input longint v);
      longint d;
      longint q;
      d = longint'(1) << TS;
      q = v / d;
      if (v < 0 && (v % d) != 0) q = q - 1;
      return q;
   endfunction

   function automatic longint obs_at(input int i);
      if (i < obs.size()) return obs[i];
      return 64'h0000_0000_DEAD_BEEF;
   endfunction

   function automatic longint obs_max();
      longint m;
      m = MINV - 1;
      foreach (obs[i]) if (obs[i] > m) m = obs[i];
      return m;
   endfunction

   task automatic model_reset();
      m_s = 0;
      m_acc = 0;
      for (int k = 0; k < N; k++) m_w[k] = 0;
      m_pend = '0;
      m_prev = '0;
      m_phase = 0;
   endtask

   // Effect of the coming rising edge given the inputs currently driven
   task automatic model_step();
      logic [N-1:0] rise;
      if (reset) return;
      rise = syn_in & ~m_prev;
      if (m_phase < N) begin
         if (m_pend[m_phase]) m_acc = m_acc + m_w[m_phase];
         m_pend[m_phase] = 1'b0;
      end else begin
         m_s = sat32(m_s - floor_div(m_s) + m_acc);
         sbq.push_back(sat32(m_s + longint'(bias)));
         m_acc = 0;
      end
      m_pend = m_pend | rise;
      m_prev = syn_in;
      if (w_we) m_w[w_addr] = longint'(w_data);
      m_phase = (m_phase == N) ? 0 : m_phase + 1;
   endtask

   task automatic tick();
      model_step();
      @(negedge clk);
      #1;
      w_we = 1'b0;
   endtask

   task automatic ticks(input int n);
      repeat (n) tick();
   endtask

   task automatic write_w(input int a, input logic signed [W-1:0] d);
      w_we = 1'b1;
      w_addr = 2'(a);
      w_data = d;
      tick();
   endtask

   task automatic do_reset();
      #1;
      reset = 1'b1;
      #1;
      check("sb_drained_at_reset", sbq.size(), 0);
      check("reset_I", I, 0);
      check("reset_i_update", i_update, 0);
      sbq.delete();
      model_reset();
      @(negedge clk);
      @(negedge clk);
      #1;
      reset = 1'b0;
   endtask

   // Monitor: every i_update pops one expected current from the scoreboard
   always @(negedge clk) begin
      if (!reset && i_update === 1'b1) begin
         obs.push_back(longint'(I));
         if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_update: got I=%h expected no update", I);
         end else begin
            check("I_update", I, sbq.pop_front());
         end
      end
   end

   initial begin
      int k;
      @(negedge clk);
      do_reset();

      // T1: single weighted spike decays frame by frame
      write_w(1, 32'sh0002_0000);
      obs.delete();
      syn_in[1] = 1'b1;
      ticks(8);
      syn_in = '0;
      ticks(25);
      while (obs.size() > 0 && obs[0] == 0) void'(obs.pop_front());
      check("T1_I0", obs_at(0), 64'h2_0000);
      check("T1_I1", obs_at(1), 64'h1_C000);
      check("T1_I2", obs_at(2), 64'h1_8800);

      // T2: line held high counts once
      do_reset();
      write_w(0, 32'sh0001_0000);
      obs.delete();
      syn_in[0] = 1'b1;
      ticks(20);
      syn_in = '0;
      ticks(12);
      check("T2_peak", obs_max(), 64'h1_0000);

      // T3: positive and negative saturation
      do_reset();
      for (int a = 0; a < N; a++) write_w(a, 32'sh7000_0000);
      obs.delete();
      syn_in = '1;
      ticks(3);
      syn_in = '0;
      ticks(10);
      check("T3_sat_max", obs_max(), MAXV);
      for (int a = 0; a < N; a++) write_w(a, 32'sh9000_0000);
      obs.delete();
      syn_in = '1;
      ticks(3);
      syn_in = '0;
      ticks(10);
      check("T3_sat_min", obs_at(obs.size() - 1), MINV);

      // T4: bias only, state stays zero
      do_reset();
      bias = 32'shFFF6_0000;
      obs.delete();
      ticks(17);
      check("T4_updates", obs.size(), 3);
      foreach (obs[i]) check("T4_bias_I", obs[i], -64'sd655360);
      bias = '0;
      obs.delete();
      ticks(6);
      check("T4_state_zero", obs_at(0), 0);

      // T5: rise while its index is being scanned counts next frame
      do_reset();
      write_w(2, 32'sh0001_0000);
      while (m_phase != 2) tick();
      obs.delete();
      syn_in[2] = 1'b1;
      ticks(3);
      syn_in = '0;
      ticks(12);
      check("T5_same_frame", obs_at(0), 0);
      check("T5_next_frame", obs_at(1), 64'h1_0000);

      // T6: reset mid-scan with a pending spike
      do_reset();
      write_w(3, 32'sh0001_0000);
      syn_in[3] = 1'b1;
      ticks(2);
      syn_in = '0;
      ticks(10);
      syn_in[3] = 1'b1;
      ticks(2);
      syn_in = '0;
      while (m_phase != 1) tick();
      do_reset();
      k = 0;
      while (k < 12) begin
         tick();
         k++;
         if (i_update === 1'b1) break;
      end
      check("T6_first_update_latency", k, 5);
      check("T6_I_after_reset", I, 0);

      // Randomized traffic
      do_reset();
      for (int c = 0; c < 900; c++) begin
         for (int b = 0; b < N; b++)
            if ($urandom_range(0, 5) == 0) syn_in[b] = ~syn_in[b];
         if ($urandom_range(0, 3) == 0) begin
            w_we = 1'b1;
            w_addr = 2'($urandom_range(0, N - 1));
            if ($urandom_range(0, 4) == 0) w_data = $urandom;
            else w_data = $urandom_range(0, 32'h60000) - 32'h30000;
         end
         if ($urandom_range(0, 49) == 0)
            bias = $urandom_range(0, 32'h40000) - 32'h20000;
         if ($urandom_range(0, 299) == 0) begin
            w_we = 1'b0;
            do_reset();
         end else begin
            tick();
         end
      end
      syn_in = '0;
      ticks(6);
      check("sb_drained_at_end", sbq.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Absolute time limit so the run always ends
   initial begin
      #500000;
      $display("FAIL timeout: got no finish expected finish before limit");
      $fatal(1, "timeout");
   end

endmodule
